// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in, serial-out transmitter with a one-word holding
//               buffer so that back-to-back words stream without idle beats.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  localparam int                 c_CNT_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [WIDTH-1:0]   w_shifted;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]   r_hold;
  logic [WIDTH-1:0]   w_hold_nxt;
  logic               r_hold_full;
  logic               w_hold_full_nxt;

  logic w_accept;
  logic w_beat;
  logic w_last_beat;

  // The output end of the shifter depends on bit order; the register always
  // moves toward that end so the next bit is presented after each beat.
  if (LSB_FIRST) begin : g_lsb_first
    assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    assign out_bit   = r_shift[0];
  end else begin : g_msb_first
    assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    assign out_bit   = r_shift[WIDTH-1];
  end

  // in_ready depends only on registered state (plus reset), never on out_ready.
  assign in_ready    = reset_n & ~r_hold_full;
  assign out_valid   = (r_state == S_SHIFT);
  assign out_first   = out_valid & (r_cnt == '0);
  assign out_last    = out_valid & (r_cnt == c_CNT_LAST);
  assign busy        = (r_state == S_SHIFT) | r_hold_full;

  assign w_accept    = in_valid & in_ready;
  assign w_beat      = out_valid & out_ready;
  assign w_last_beat = w_beat & (r_cnt == c_CNT_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = d;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_beat) begin
          if (r_cnt != c_CNT_LAST) begin
            w_shift_nxt = w_shifted;
            w_cnt_nxt   = r_cnt + c_CNT_W'(1);
          end else if (r_hold_full) begin
            w_shift_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
            w_cnt_nxt       = '0;
          end else if (w_accept) begin
            w_shift_nxt = d;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        // Accept implies the hold is empty; only the final-beat case bypasses it.
        if (w_accept && !w_last_beat) begin
          w_hold_nxt      = d;
          w_hold_full_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Scoreboard bench driving an LSB-first and an MSB-first
//               serializer with identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  localparam int c_W = 4;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [c_W-1:0] d;
  logic           in_valid;
  logic           out_ready;
  logic           rand_rdy;

  logic in_ready_l, out_bit_l, out_valid_l, out_first_l, out_last_l, busy_l;
  logic in_ready_m, out_bit_m, out_valid_m, out_first_m, out_last_m, busy_m;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t q_lsb[$];
  beat_t q_msb[$];
  int    inflight = 0;
  logic  armed    = 1'b0;
  logic  in_rst   = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(c_W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset_n(reset_n), .d(d), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_bit(out_bit_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_first(out_first_l), .out_last(out_last_l),
    .busy(busy_l)
  );

  piso_serializer #(.WIDTH(c_W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset_n(reset_n), .d(d), .in_valid(in_valid),
    .in_ready(in_ready_m), .out_bit(out_bit_m), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_first(out_first_m), .out_last(out_last_m),
    .busy(busy_m)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the model state reflects what should hold after the last edge;
  // compare first, then advance the model by what happens at the next edge.
  always @(negedge clk) begin
    logic  ready_now;
    logic  valid_now;
    beat_t e;
    if (armed) begin
      valid_now = (inflight > 0);
      chk("in_ready_lsb",  in_ready_l,  reset_n && inflight < 2);
      chk("in_ready_msb",  in_ready_m,  reset_n && inflight < 2);
      chk("out_valid_lsb", out_valid_l, valid_now);
      chk("out_valid_msb", out_valid_m, valid_now);
      chk("busy_lsb",      busy_l,      valid_now);
      chk("busy_msb",      busy_m,      valid_now);
      if (in_rst) begin
        chk("rst_bit_lsb", out_bit_l, 1'b0);
        chk("rst_bit_msb", out_bit_m, 1'b0);
      end
      if (valid_now && q_lsb.size() > 0 && q_msb.size() > 0) begin
        chk("bit_lsb",   out_bit_l,   q_lsb[0].b);
        chk("first_lsb", out_first_l, q_lsb[0].f);
        chk("last_lsb",  out_last_l,  q_lsb[0].l);
        chk("bit_msb",   out_bit_m,   q_msb[0].b);
        chk("first_msb", out_first_m, q_msb[0].f);
        chk("last_msb",  out_last_m,  q_msb[0].l);
      end else begin
        chk("first_idle", out_first_l | out_first_m, 1'b0);
        chk("last_idle",  out_last_l | out_last_m,   1'b0);
      end
    end
    if (!reset_n) begin
      inflight = 0;
      q_lsb.delete();
      q_msb.delete();
      in_rst = 1'b1;
      armed  = 1'b1;
    end else begin
      in_rst    = 1'b0;
      ready_now = (inflight < 2);
      if (inflight > 0 && out_ready && q_lsb.size() > 0) begin
        if (q_lsb[0].l) inflight--;
        void'(q_lsb.pop_front());
        if (q_msb.size() > 0) void'(q_msb.pop_front());
      end
      if (in_valid && ready_now) begin
        for (int i = 0; i < c_W; i++) begin
          e.f = (i == 0);
          e.l = (i == c_W - 1);
          e.b = d[i];
          q_lsb.push_back(e);
          e.b = d[c_W-1-i];
          q_msb.push_back(e);
        end
        inflight++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [c_W-1:0] w);
    logic rdy;
    int   n;
    n        = 0;
    in_valid = 1'b1;
    d        = w;
    forever begin
      @(negedge clk);
      rdy = in_ready_l;
      step();
      if (rdy) break;
      n++;
      if (n > 64) begin
        chk("send_timeout", 1'b0, 1'b1);
        break;
      end
    end
    in_valid = 1'b0;
    d        = 4'($urandom);
  endtask

  logic bp_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    d         = '0;
    out_ready = 1'b0;
    rand_rdy  = 1'b0;
    repeat (3) step();
    reset_n   = 1'b1;
    out_ready = 1'b1;

    send(4'b1011);
    idle(6);

    send(4'hA);
    send(4'h5);
    idle(10);

    send(4'b0110);
    for (int i = 0; i < 7; i++) begin
      out_ready = bp_pat[i];
      step();
    end
    out_ready = 1'b1;
    idle(6);

    send(4'h9);
    send(4'hC);
    send(4'h3);
    idle(14);

    send(4'hF);
    send(4'hF);
    step();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    send(4'h1);
    idle(6);

    send(4'b1000);
    idle(6);

    rand_rdy = 1'b1;
    repeat (300) begin
      send(4'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    idle(30);
    chk("drain_lsb", q_lsb.size() == 0, 1'b1);
    chk("drain_msb", q_msb.size() == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter, the opposite direction of a parallel capture register.
- Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per accepted output beat.
- A one-word holding buffer lets consecutive words stream with no idle cycle between them.
- Feeds serial links and bit-serial datapaths; pairs with a serial-in, parallel-out receiver.

Parameters:
- WIDTH, 4: word width in bits; legal values are >= 2.
- LSB_FIRST, 1: 1 transmits bit 0 first; 0 transmits bit WIDTH-1 first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- d  input  WIDTH  parallel word to transmit.
- in_valid  input  1  d is valid.
- in_ready  output  1  block can accept d this cycle.
- out_bit  output  1  current serial bit.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream consumes out_bit this cycle.
- out_first  output  1  out_bit is the first bit of its word.
- out_last  output  1  out_bit is the last bit of its word.
- busy  output  1  a word is in the shifter or in the holding buffer.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE; shifter, counter and holding buffer are cleared; hold_full=0.
  - out_valid, out_bit, out_first, out_last and busy are all 0.
  - in_ready is forced to 0 while reset_n=0.
  - A reset mid-word discards the partial word and any held word, with no further output beats.
- Handshakes:
  - Input accept = in_valid & in_ready at a clock edge.
  - Output beat = out_valid & out_ready at a clock edge.
- in_ready = !hold_full. It is driven from registers only, with no combinational path from out_ready or in_valid.
- State machine, states IDLE and SHIFT:
  - IDLE: out_valid=0. On accept, load d into the shifter, set cnt=0, go to SHIFT. out_valid=1 on the next cycle (latency 1 cycle).
  - SHIFT: out_valid=1. On a beat with cnt<WIDTH-1, shift the register toward the output end and increment cnt.
  - SHIFT, beat with cnt==WIDTH-1 and hold_full: load the shifter from the holding buffer, clear hold_full, cnt=0, stay in SHIFT. No bubble.
  - SHIFT, beat with cnt==WIDTH-1, hold empty and accept in the same cycle: load d directly into the shifter (bypass), cnt=0, stay in SHIFT.
  - SHIFT, beat with cnt==WIDTH-1, hold empty and no accept: go to IDLE.
  - SHIFT, accept not covered by the bypass case: write d into the holding buffer, set hold_full=1.
- Outputs:
  - out_bit = LSB_FIRST ? shifter[0] : shifter[WIDTH-1].
  - out_first = out_valid & (cnt==0); out_last = out_valid & (cnt==WIDTH-1).
  - Without a beat, out_bit, out_first and out_last hold stable; bit order and value are unaffected by any amount of backpressure.
  - busy = (state==SHIFT) | hold_full.
- Widths and ordering:
  - cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1.
  - Words leave in acceptance order; no word is dropped or duplicated.
- Simultaneous final beat, hold_full=1 and in_valid=1: in_ready is 0, so d is not accepted. The held word moves to the shifter and in_ready rises on the next cycle.

Test Plan:
- Single word: reset, then accept d=4'b1011 with out_ready=1.
  - Cycles +1..+4: out_bit = 1,1,0,1.
  - out_first only on +1, out_last only on +4.
  - busy=0 and out_valid=0 on +5.
- Streaming: accept 4'hA then 4'h5 back-to-back, out_ready=1.
  - Eight contiguous valid bits 0,1,0,1,1,0,1,0 with no gap.
  - in_ready=0 while the hold is full.
- Backpressure: accept 4'b0110 and toggle out_ready 1,0,0,1,1,0,1.
  - Exactly the bits 0,1,1,0 are delivered on beats only.
  - out_bit is unchanged on stall cycles.
- Simultaneous final beat: hold full with 4'hC, in_valid=1 with 4'h3 on the last beat of the current word.
  - 4'hC starts the next cycle with no bubble.
  - 4'h3 is accepted on the following cycle and transmitted after 4'hC.
- Reset mid-word: pull reset_n low after 2 bits of 4'hF with the hold full.
  - Next cycle: out_valid=0, busy=0, in_ready=0 during reset.
  - After release, in_ready=1 and a fresh 4'h1 transmits as 1,0,0,0.
- LSB_FIRST=0, d=4'b1000: out_bit = 1,0,0,0.
